// File: rtl/alu_cmd_sequencer_if.sv
// Command/result handshake bundle between a producer/consumer and alu_cmd_sequencer.
// master = command producer and result consumer, slave = the sequencer.
interface alu_cmd_sequencer_if #(
   parameter int DW  = 4,
   parameter int OPW = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_a;
   logic [DW-1:0]     in_b;
   logic [OPW-1:0]    in_op;
   logic              out_valid;
   logic              out_ready;
   logic [2*DW-1:0]   out_data;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a small FIFO, issues them one at a time and returns results in order.
// Optional ALU_CMD_DIV0_FLAG_EN adds out_div0, flagging a divide (sel 3'b111) with b==0.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued command
// EXEC  | operands presented, ALU registers its result at this edge
// CAPT  | ALU result captured into out_data at this edge
// DONE  | result offered on out_valid until accepted
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int DW    = 4,
   parameter int OPW   = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   alu_cmd_sequencer_if.slave      bus,
   output logic [DW-1:0]           alu_a,
   output logic [DW-1:0]           alu_b,
   output logic [OPW-1:0]          alu_sel,
   input  logic [2*DW-1:0]         alu_result,
`ifdef ALU_CMD_DIV0_FLAG_EN
   output logic                    out_div0,
`endif
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2*DW + OPW;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, DONE} state_t;

   state_t         state, state_nxt;
   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic           push, pop, not_empty;

   // in_ready comes only from the registered count, never from a same-cycle pop
   assign bus.in_ready  = (count != FULL_CNT);
   assign not_empty     = (count != '0);
   assign push          = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (not_empty) begin
               pop       = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = CAPT;
         CAPT: state_nxt = DONE;
         DONE: begin
            if (bus.out_ready) begin
               if (not_empty) begin
                  pop       = 1'b1;
                  state_nxt = EXEC;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_op};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
      end else if (pop) begin
         {alu_a, alu_b, alu_sel} <= mem[rd_ptr];
      end
   end

   // operands are still held from EXEC during CAPT, so the flag sees the issued command
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_data <= '0;
      end else if (state == CAPT) begin
         bus.out_data <= alu_result;
      end
   end

`ifdef ALU_CMD_DIV0_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         out_div0 <= 1'b0;
      end else if (state == CAPT) begin
         out_div0 <= (alu_sel == OPW'(7)) && (alu_b == '0);
      end
   end
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized checks of alu_cmd_sequencer against a timeline/queue reference model.
module tb_alu_cmd_sequencer;
   logic        clk;
   logic        rst;
   logic [3:0]  alu_a, alu_b;
   logic [2:0]  alu_sel;
   logic [7:0]  alu_result = 8'h00;
   logic [2:0]  count;
`ifdef ALU_CMD_DIV0_FLAG_EN
   logic        out_div0;
`endif

   alu_cmd_sequencer_if #(.DW(4), .OPW(3)) bus ();

   alu_cmd_sequencer #(.DEPTH(4), .DW(4), .OPW(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
`ifdef ALU_CMD_DIV0_FLAG_EN
      .out_div0   (out_div0),
`endif
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      case (op)
         3'd0:    return {4'h0, a} + {4'h0, b};
         3'd1:    return {4'h0, a} - {4'h0, b};
         3'd2:    return {4'h0, a & b};
         3'd3:    return {4'h0, a | b};
         3'd4:    return {4'h0, a ^ b};
         3'd5:    return ~{b, a};
         3'd6:    return {4'h0, a} * {4'h0, b};
         default: return (b == 4'h0) ? 8'h00 : {4'h0, a} / {4'h0, b};
      endcase
   endfunction

   // stand-in for the downstream ALU: one registered stage
   always @(posedge clk) alu_result <= alu_f(alu_a, alu_b, alu_sel);

   typedef struct {
      logic [3:0]  a;
      logic [3:0]  b;
      logic [2:0]  op;
      int unsigned acc_edge;
   } cmd_t;

   cmd_t         pend[$];
   cmd_t         cur;
   logic         busy    = 1'b0;
   int unsigned  issue   = 0;
   int unsigned  cyc     = 0;
   logic [3:0]   m_a     = 4'h0, m_b = 4'h0;
   logic [2:0]   m_op    = 3'h0;
   logic [7:0]   m_data  = 8'h00;
   logic         m_div0  = 1'b0;
   logic         m_valid = 1'b0;
   logic         last_acc;
   logic [7:0]   hs_data[$];
   int unsigned  hs_cyc[$];
   int           n_checks = 0;
   int           n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, advance the model, compare after the edge.
   task automatic tick();
      logic rs, acc_m, hs_m;
      cmd_t c;
      rs    = rst;
      acc_m = bus.in_valid && (pend.size() < 4);
      hs_m  = m_valid && bus.out_ready;
      if (!rs && bus.out_valid && bus.out_ready) begin
         hs_data.push_back(bus.out_data);
         hs_cyc.push_back(cyc + 1);
      end
      last_acc   = acc_m && !rs;
      c.a        = bus.in_a;
      c.b        = bus.in_b;
      c.op       = bus.in_op;
      c.acc_edge = 0;
      @(posedge clk);
      cyc++;
      if (rs) begin
         pend.delete();
         busy   = 1'b0;
         m_a    = 4'h0;
         m_b    = 4'h0;
         m_op   = 3'h0;
         m_data = 8'h00;
         m_div0 = 1'b0;
      end else begin
         if (hs_m) busy = 1'b0;
         if (!busy && pend.size() != 0 && pend[0].acc_edge < cyc) begin
            cur   = pend.pop_front();
            busy  = 1'b1;
            issue = cyc;
            m_a   = cur.a;
            m_b   = cur.b;
            m_op  = cur.op;
         end
         if (acc_m) begin
            c.acc_edge = cyc;
            pend.push_back(c);
         end
         if (busy && cyc == issue + 2) begin
            m_data = alu_f(cur.a, cur.b, cur.op);
            m_div0 = (cur.op == 3'd7) && (cur.b == 4'h0);
         end
      end
      m_valid = busy && (cyc >= issue + 2);
      @(negedge clk);
      check("count",     32'(count),         32'(pend.size()));
      check("in_ready",  32'(bus.in_ready),  32'(pend.size() < 4));
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("out_data",  32'(bus.out_data),  32'(m_data));
      check("alu_ops",   {21'h0, alu_a, alu_b, alu_sel}, {21'h0, m_a, m_b, m_op});
`ifdef ALU_CMD_DIV0_FLAG_EN
      check("out_div0",  32'(out_div0),      32'(m_div0));
`endif
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 20);
      check("send_accept", 32'(last_acc), 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         tick();
         n++;
      end
      check("wait_valid", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while ((bus.out_valid || count != 0 || busy) && n < 60) begin
         tick();
         n++;
      end
      check("drain_idle", 32'(bus.out_valid || count != 0), 32'd0);
   endtask

   initial begin
      int n;
      logic [3:0] fa[6], fb[6];
      logic [2:0] fo[6];
      logic [7:0] exp_burst[4];

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = 4'h0;
      bus.in_b      = 4'h0;
      bus.in_op     = 3'h0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      check("rst_count",    32'(count),         32'd0);
      check("rst_in_ready", 32'(bus.in_ready),  32'd1);
      check("rst_out_data", 32'(bus.out_data),  32'd0);

      // basic add and latency
      bus.out_ready = 1'b1;
      send(4'd3, 4'd5, 3'd0);
      n = 0;
      while (!bus.out_valid && n < 10) begin
         tick();
         n++;
      end
      check("latency", 32'(n), 32'd3);
      check("add_data", 32'(bus.out_data), 32'h08);
      tick();
      check("add_count", 32'(count), 32'd0);

      // ordered burst
      hs_data.delete();
      hs_cyc.delete();
      send(4'd7, 4'd2, 3'd1);
      send(4'd12, 4'd10, 3'd6);
      send(4'd9, 4'd4, 3'd7);
      send(4'd5, 4'd3, 3'd5);
      n = 0;
      while (hs_data.size() < 4 && n < 40) begin
         tick();
         n++;
      end
      check("burst_n", 32'(hs_data.size()), 32'd4);
      exp_burst = '{8'h05, 8'h78, 8'h02, 8'hCA};
      for (int i = 0; i < 4; i++)
         if (i < hs_data.size()) check("burst_data", 32'(hs_data[i]), 32'(exp_burst[i]));
      for (int i = 0; i + 1 < 4; i++)
         if (i + 1 < hs_cyc.size()) check("burst_gap", hs_cyc[i+1] - hs_cyc[i], 32'd3);
      drain();

      // full / backpressure
      hs_data.delete();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         fa[i] = 4'($urandom);
         fb[i] = 4'($urandom);
         fo[i] = 3'($urandom);
      end
      for (int i = 0; i < 5; i++) send(fa[i], fb[i], fo[i]);
      check("full_count", 32'(count), 32'd4);
      check("full_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_a     = fa[5];
      bus.in_b     = fb[5];
      bus.in_op    = fo[5];
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_blocked", 32'(last_acc), 32'd0);
      end
      check("full_hold_valid", 32'(bus.out_valid), 32'd1);
      check("full_hold_data", 32'(bus.out_data), 32'(alu_f(fa[0], fb[0], fo[0])));
      bus.out_ready = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 10);
      check("retry_accept", 32'(last_acc), 32'd1);
      bus.in_valid = 1'b0;
      n = 0;
      while (hs_data.size() < 6 && n < 60) begin
         tick();
         n++;
      end
      check("full_drain_n", 32'(hs_data.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < hs_data.size()) check("full_order", 32'(hs_data[i]), 32'(alu_f(fa[i], fb[i], fo[i])));
      drain();

      // simultaneous push and pop keeps count
      bus.out_ready = 1'b0;
      send(4'd1, 4'd2, 3'd0);
      send(4'd4, 4'd4, 3'd6);
      send(4'd8, 4'd3, 3'd4);
      wait_valid();
      check("pp_count_before", 32'(count), 32'd2);
      bus.in_valid  = 1'b1;
      bus.in_a      = 4'd15;
      bus.in_b      = 4'd1;
      bus.in_op     = 3'd1;
      bus.out_ready = 1'b1;
      tick();
      check("pp_accept", 32'(last_acc), 32'd1);
      check("pp_count_after", 32'(count), 32'd2);
      drain();

      // reset while in CAPT with three queued
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(4'($urandom), 4'($urandom), 3'($urandom));
      wait_valid();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      tick();
      check("capt_busy", 32'(busy && cyc == issue + 1), 32'd1);
      check("capt_count", 32'(count), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_sel", 32'(alu_sel), 32'd0);
      hs_data.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("no_stale", 32'(hs_data.size()), 32'd0);

`ifdef ALU_CMD_DIV0_FLAG_EN
      send(4'd9, 4'd0, 3'd7);
      wait_valid();
      check("div0_data", 32'(bus.out_data), 32'h00);
      check("div0_flag", 32'(out_div0), 32'd1);
      tick();
      send(4'd9, 4'd3, 3'd7);
      wait_valid();
      check("div_data", 32'(bus.out_data), 32'h03);
      check("div_flag", 32'(out_div0), 32'd0);
      drain();
`endif

      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.in_a      = 4'($urandom);
         bus.in_b      = 4'($urandom);
         bus.in_op     = 3'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         rst           = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
